// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sersub_state_t;

    localparam int unsigned SERSUB_MAX_WIDTH = 64;
    localparam int unsigned SERSUB_MIN_WIDTH = 2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first, one full-subtractor cell, WIDTH cycles).
// Optional zero_o flag port is built only when SERSUB_ZERO_FLAG_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
`ifdef SERSUB_ZERO_FLAG_EN
    ,
    output logic             zero_o
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sersub_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERSUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] acc_next;

    full_subtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bin_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    assign acc_next = {cell_d, acc_q[WIDTH-1:1]};

    // Result is built in acc_q and copied to diff_q only on completion, so
    // diff_o never shows a partial value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_next;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = cell_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d   = acc_next;
                    borrow_d = cell_bout;
`ifdef SERSUB_ZERO_FLAG_EN
                    zero_d   = (acc_next == '0);
`endif
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERSUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
    assign zero_o      = zero_q;
`endif

endmodule
